dm_abstractcmd_ctrl: RTL and testbench

Sequencing controller for abstract commands in the debug module. It accepts command writes from the DMI register file and latches the command for the abstract-command instruction generator. It raises the go flag for the halted hart, then tracks the hart's going/halted/exception acknowledgements written into debug memory. It owns `busy` and the sticky `cmderr` field of `abstractcs`.

---
 rtl/dm_pkg.sv | 24 ++
 rtl/dm_abstractcmd_ctrl_if.sv | 36 +++
 rtl/dm_cmd_watchdog.sv | 29 ++
 rtl/dm_abstractcmd_ctrl.sv | 161 ++++++++++++++++
 tb/tb_dm_abstractcmd_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared debug-module definitions: abstractcs.cmderr codes, the abstract-command
// FSM state encoding, and the debug-memory flag offsets that the hart writes.
package dm_pkg;

  localparam logic [2:0] CMDERR_NONE       = 3'd0;
  localparam logic [2:0] CMDERR_BUSY       = 3'd1;
  localparam logic [2:0] CMDERR_NOTSUP     = 3'd2;
  localparam logic [2:0] CMDERR_EXCEPTION  = 3'd3;
  localparam logic [2:0] CMDERR_HALTRESUME = 3'd4;
  localparam logic [2:0] CMDERR_OTHER      = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_GO,
    ST_EXEC
  } cmd_state_e;

  // Debug-memory offsets of the flag words the hart writes from the park loop.
  localparam logic [11:0] FLAG_HALTED_OFFSET    = 12'h100;
  localparam logic [11:0] FLAG_GOING_OFFSET     = 12'h104;
  localparam logic [11:0] FLAG_EXCEPTION_OFFSET = 12'h10C;

endpackage

// File: rtl/dm_abstractcmd_ctrl_if.sv
// Handshake bundle between the DMI register file / hart flag decode and the
// abstract-command controller. slave = controller side, master = driver side.
interface dm_abstractcmd_ctrl_if;
  import dm_pkg::*;

  logic        cmd_we_i;
  logic [31:0] cmd_wdata_i;
  logic [31:0] cmd_o;
  logic        unsupported_command_i;
  logic        cmderr_we_i;
  logic [2:0]  cmderr_wdata_i;
  logic        dmi_busy_access_i;
  logic        autoexec_trig_i;
  logic        halted_i;
  logic        hart_going_ack_i;
  logic        hart_halted_ack_i;
  logic        hart_exception_i;
  logic        go_o;
  logic        busy_o;
  logic [2:0]  cmderr_o;

  modport slave (
    input  cmd_we_i, cmd_wdata_i, unsupported_command_i, cmderr_we_i,
           cmderr_wdata_i, dmi_busy_access_i, autoexec_trig_i, halted_i,
           hart_going_ack_i, hart_halted_ack_i, hart_exception_i,
    output cmd_o, go_o, busy_o, cmderr_o
  );

  modport master (
    output cmd_we_i, cmd_wdata_i, unsupported_command_i, cmderr_we_i,
           cmderr_wdata_i, dmi_busy_access_i, autoexec_trig_i, halted_i,
           hart_going_ack_i, hart_halted_ack_i, hart_exception_i,
    input  cmd_o, go_o, busy_o, cmderr_o
  );

endinterface

// File: rtl/dm_cmd_watchdog.sv
// Clearable saturating cycle counter bounding the GO+EXEC phase of an
// abstract command. TIMEOUT_CYCLES = 0 disables expiry.
module dm_cmd_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  // Count enabled cycles, saturating at the limit; clear has priority.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_cnt <= '0;
    end else if (en_i && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired_o = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_MAX);

endmodule

// File: rtl/dm_abstractcmd_ctrl.sv
// Abstract-command sequencing controller: latches DMI command writes, runs the
// IDLE/CHECK/GO/EXEC handshake with the halted hart, and owns abstractcs.busy
// and the sticky cmderr field. Optional autoexec re-run: `DM_AUTOEXEC_EN.
module dm_abstractcmd_ctrl
  import dm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic                  clk_i,
  input logic                  rst_i,
  dm_abstractcmd_ctrl_if.slave bus
);

  cmd_state_e  r_state;
  cmd_state_e  w_state_next;
  logic [31:0] r_cmd;
  logic [2:0]  r_cmderr;
  logic [2:0]  w_cmderr_cleared;
  logic        w_err_set;
  logic [2:0]  w_err_code;
  logic        w_latch_cmd;
  logic        w_enter_go;
  logic        w_wd_expired;
  logic        w_autoexec;
  logic        w_start;
  logic        w_busy;

`ifdef DM_AUTOEXEC_EN
  assign w_autoexec = bus.autoexec_trig_i;
`else
  logic w_unused_autoexec;
  assign w_unused_autoexec = bus.autoexec_trig_i;
  assign w_autoexec        = 1'b0;
`endif

  assign w_busy = (r_state != ST_IDLE);

  dm_cmd_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (w_enter_go),
    .en_i     ((r_state == ST_GO) || (r_state == ST_EXEC)),
    .expired_o(w_wd_expired)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus the error event raised this cycle.
  always_comb begin
    w_state_next = r_state;
    w_err_set    = 1'b0;
    w_err_code   = CMDERR_NONE;
    w_latch_cmd  = 1'b0;
    w_enter_go   = 1'b0;
    w_start      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // A write beats a simultaneous autoexec; both need a clean cmderr.
        if (r_cmderr == CMDERR_NONE) begin
          w_latch_cmd = bus.cmd_we_i;
          w_start     = bus.cmd_we_i || w_autoexec;
        end
        if (w_start) begin
          if (!bus.halted_i) begin
            w_err_set  = 1'b1;
            w_err_code = CMDERR_HALTRESUME;
          end else begin
            w_state_next = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (bus.unsupported_command_i) begin
          w_err_set    = 1'b1;
          w_err_code   = CMDERR_NOTSUP;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_GO;
          w_enter_go   = 1'b1;
        end
      end
      ST_GO: begin
        if (w_wd_expired) begin
          w_err_set    = 1'b1;
          w_err_code   = CMDERR_OTHER;
          w_state_next = ST_IDLE;
        end else if (bus.hart_exception_i) begin
          w_err_set    = 1'b1;
          w_err_code   = CMDERR_EXCEPTION;
          w_state_next = ST_IDLE;
        end else if (bus.hart_going_ack_i) begin
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (w_wd_expired) begin
          w_err_set    = 1'b1;
          w_err_code   = CMDERR_OTHER;
          w_state_next = ST_IDLE;
        end else if (bus.hart_exception_i) begin
          w_err_set    = 1'b1;
          w_err_code   = CMDERR_EXCEPTION;
          w_state_next = ST_IDLE;
        end else if (bus.hart_halted_ack_i) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    // Accesses while busy flag an error but leave the running command alone;
    // a command-level error in the same cycle takes precedence.
    if (w_busy && !w_err_set &&
        (bus.cmd_we_i || bus.dmi_busy_access_i || w_autoexec)) begin
      w_err_set  = 1'b1;
      w_err_code = CMDERR_BUSY;
    end
  end

  // Latched command for the instruction generator.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cmd <= '0;
    end else if (w_latch_cmd) begin
      r_cmd <= bus.cmd_wdata_i;
    end
  end

  // W1C first, then a new error loads only into a cleared field.
  always_comb begin
    w_cmderr_cleared = r_cmderr;
    if (bus.cmderr_we_i) begin
      w_cmderr_cleared = r_cmderr & ~bus.cmderr_wdata_i;
    end
  end

  // Sticky cmderr register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cmderr <= CMDERR_NONE;
    end else if (w_err_set && (w_cmderr_cleared == CMDERR_NONE)) begin
      r_cmderr <= w_err_code;
    end else begin
      r_cmderr <= w_cmderr_cleared;
    end
  end

  assign bus.cmd_o    = r_cmd;
  assign bus.go_o     = (r_state == ST_GO);
  assign bus.busy_o   = w_busy;
  assign bus.cmderr_o = r_cmderr;

endmodule

// File: tb/tb_dm_abstractcmd_ctrl.sv
// Self-checking bench for dm_abstractcmd_ctrl. Each scenario is described as a
// relative cycle timeline (write at cycle 0); expected busy/go/cmderr windows are
// computed from the protocol timing rules with plain arithmetic.
module tb_dm_abstractcmd_ctrl;
  import dm_pkg::*;

  localparam int unsigned TO = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  dm_abstractcmd_ctrl_if bus ();

  dm_abstractcmd_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_idle();
    bus.cmd_we_i              = 1'b0;
    bus.cmd_wdata_i           = '0;
    bus.unsupported_command_i = 1'b0;
    bus.cmderr_we_i           = 1'b0;
    bus.cmderr_wdata_i        = '0;
    bus.dmi_busy_access_i     = 1'b0;
    bus.autoexec_trig_i       = 1'b0;
    bus.hart_going_ack_i      = 1'b0;
    bus.hart_halted_ack_i     = 1'b0;
    bus.hart_exception_i      = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    drive_idle();
    next_cycle();
    next_cycle();
    for (int unsigned c = 0; c < 3; c++) begin
      @(negedge clk_i);
      n_vec++;
      if ({bus.cmd_o, bus.busy_o, bus.go_o, bus.cmderr_o} !== 37'd0) begin
        n_err++;
        $display("FAIL reset c%0d got cmd=%h busy=%b go=%b cmderr=%0d want all 0",
                 c, bus.cmd_o, bus.busy_o, bus.go_o, bus.cmderr_o);
      end
      next_cycle();
      rst_i = 1'b0;
    end
  endtask

  task automatic test_command(input int unsigned iters);
    for (int unsigned it = 0; it < iters; it++) begin
      int unsigned dg, dh, tm, tk;
      logic        stray;
      logic [31:0] data;
      logic [4:0]  exp;
      dg    = $urandom_range(0, 4);
      dh    = $urandom_range(1, 5);
      data  = (it == 0) ? 32'h0022_1008 : $urandom;
      stray = 1'($urandom_range(0, 1));
      tm    = 2 + dg;
      tk    = tm + dh;
      for (int unsigned c = 0; c <= tk + 1; c++) begin
        drive_idle();
        bus.cmd_we_i          = (c == 0);
        bus.cmd_wdata_i       = data;
        bus.hart_going_ack_i  = (c == tm);
        // a halted flag while still in GO must be ignored
        bus.hart_halted_ack_i = (c == tk) || (stray && dg > 0 && c == 2);
        exp = {(c >= 1 && c <= tk), (c >= 2 && c <= tm), CMDERR_NONE};
        @(negedge clk_i);
        n_vec++;
        if ({bus.busy_o, bus.go_o, bus.cmderr_o} !== exp) begin
          n_err++;
          $display("FAIL command it%0d c%0d busy,go,cmderr got %b,%b,%0d want %b,%b,%0d",
                   it, c, bus.busy_o, bus.go_o, bus.cmderr_o, exp[4], exp[3], exp[2:0]);
        end
        if (c >= 1) begin
          n_vec++;
          if (bus.cmd_o !== data) begin
            n_err++;
            $display("FAIL command_latch it%0d c%0d got %h want %h", it, c, bus.cmd_o, data);
          end
        end
        next_cycle();
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b, want;
    logic [4:0]  exp;
    a = $urandom;
    b = ~a;
    for (int unsigned c = 0; c <= 8; c++) begin
      drive_idle();
      bus.cmd_we_i          = (c == 0) || (c == 4);
      bus.cmd_wdata_i       = (c < 4) ? a : b;
      bus.hart_going_ack_i  = (c == 2) || (c == 6);
      bus.hart_halted_ack_i = (c == 3) || (c == 7);
      exp  = {((c % 4) != 0) && (c < 8), (c % 4) == 2, CMDERR_NONE};
      want = (c <= 4) ? a : b;
      @(negedge clk_i);
      n_vec++;
      if ({bus.busy_o, bus.go_o, bus.cmderr_o} !== exp) begin
        n_err++;
        $display("FAIL back_to_back c%0d busy,go,cmderr got %b,%b,%0d want %b,%b,%0d",
                 c, bus.busy_o, bus.go_o, bus.cmderr_o, exp[4], exp[3], exp[2:0]);
      end
      if (c >= 1) begin
        n_vec++;
        if (bus.cmd_o !== want) begin
          n_err++;
          $display("FAIL back_to_back_cmd c%0d got %h want %h", c, bus.cmd_o, want);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_not_halted();
    logic [31:0] a, b, want;
    logic [4:0]  exp;
    a = $urandom;
    b = a ^ 32'h0F0F_F0F0;
    for (int unsigned c = 0; c <= 9; c++) begin
      drive_idle();
      bus.halted_i          = (c >= 5);
      bus.cmd_we_i          = (c == 0) || (c == 1) || (c == 5);
      bus.cmd_wdata_i       = (c == 0) ? a : b;
      bus.cmderr_we_i       = (c == 2) || (c == 3);
      bus.cmderr_wdata_i    = (c == 2) ? 3'b011 : 3'b100;
      bus.hart_going_ack_i  = (c == 7);
      bus.hart_halted_ack_i = (c == 8);
      exp  = {(c >= 6 && c <= 8), (c == 7), (c >= 1 && c <= 3) ? CMDERR_HALTRESUME : CMDERR_NONE};
      want = (c <= 5) ? a : b;
      @(negedge clk_i);
      n_vec++;
      if ({bus.busy_o, bus.go_o, bus.cmderr_o} !== exp) begin
        n_err++;
        $display("FAIL not_halted c%0d busy,go,cmderr got %b,%b,%0d want %b,%b,%0d",
                 c, bus.busy_o, bus.go_o, bus.cmderr_o, exp[4], exp[3], exp[2:0]);
      end
      if (c >= 1) begin
        n_vec++;
        if (bus.cmd_o !== want) begin
          n_err++;
          $display("FAIL not_halted_cmd c%0d got %h want %h", c, bus.cmd_o, want);
        end
      end
      next_cycle();
    end
    bus.halted_i = 1'b1;
  endtask

  task automatic test_unsupported();
    logic [31:0] a;
    logic [4:0]  exp;
    a = $urandom;
    for (int unsigned c = 0; c <= 6; c++) begin
      drive_idle();
      bus.cmd_we_i              = (c == 0) || (c == 3);
      bus.cmd_wdata_i           = (c == 0) ? a : ~a;
      bus.unsupported_command_i = (c == 1);
      bus.cmderr_we_i           = (c == 5);
      bus.cmderr_wdata_i        = 3'b111;
      exp = {(c == 1), 1'b0, (c >= 2 && c <= 5) ? CMDERR_NOTSUP : CMDERR_NONE};
      @(negedge clk_i);
      n_vec++;
      if ({bus.busy_o, bus.go_o, bus.cmderr_o} !== exp) begin
        n_err++;
        $display("FAIL unsupported c%0d busy,go,cmderr got %b,%b,%0d want %b,%b,%0d",
                 c, bus.busy_o, bus.go_o, bus.cmderr_o, exp[4], exp[3], exp[2:0]);
      end
      if (c >= 1) begin
        n_vec++;
        if (bus.cmd_o !== a) begin
          n_err++;
          $display("FAIL unsupported_cmd c%0d got %h want %h", c, bus.cmd_o, a);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_busy_err();
    logic [31:0] a;
    logic [4:0]  exp;
    int unsigned e;
    logic        sel;
    // Access in a busy state; later exception cannot overwrite the sticky code.
    a   = $urandom;
    e   = $urandom_range(1, 3);
    sel = 1'($urandom_range(0, 1));
    for (int unsigned c = 0; c <= 7; c++) begin
      drive_idle();
      bus.cmd_we_i          = (c == 0) || (!sel && c == e);
      bus.cmd_wdata_i       = (c == 0) ? a : ~a;
      bus.dmi_busy_access_i = sel && (c == e);
      bus.hart_going_ack_i  = (c == 2);
      bus.hart_exception_i  = (c == 4);
      bus.cmderr_we_i       = (c == 6);
      bus.cmderr_wdata_i    = 3'b001;
      exp = {(c >= 1 && c <= 4), (c == 2), (c >= e + 1 && c <= 6) ? CMDERR_BUSY : CMDERR_NONE};
      @(negedge clk_i);
      n_vec++;
      if ({bus.busy_o, bus.go_o, bus.cmderr_o} !== exp) begin
        n_err++;
        $display("FAIL busy_err e%0d sel%0d c%0d busy,go,cmderr got %b,%b,%0d want %b,%b,%0d",
                 e, sel, c, bus.busy_o, bus.go_o, bus.cmderr_o, exp[4], exp[3], exp[2:0]);
      end
      if (c >= 1) begin
        n_vec++;
        if (bus.cmd_o !== a) begin
          n_err++;
          $display("FAIL busy_err_cmd c%0d got %h want %h", c, bus.cmd_o, a);
        end
      end
      next_cycle();
    end
    // Clear and re-set in one cycle keeps BUSY; after a clean clear an exception loads.
    for (int unsigned c = 0; c <= 9; c++) begin
      drive_idle();
      bus.cmd_we_i          = (c == 0);
      bus.cmd_wdata_i       = a;
      bus.hart_going_ack_i  = (c == 2);
      bus.dmi_busy_access_i = (c == 3) || (c == 4);
      bus.cmderr_we_i       = (c == 4) || (c == 5) || (c == 7) || (c == 8);
      bus.cmderr_wdata_i    = (c == 7) ? 3'b100 : (c == 8) ? 3'b111 : 3'b001;
      bus.hart_exception_i  = (c == 6);
      bus.hart_halted_ack_i = (c == 6);
      exp = {(c >= 1 && c <= 6), (c == 2),
             (c == 4 || c == 5) ? CMDERR_BUSY : (c == 7 || c == 8) ? CMDERR_EXCEPTION : CMDERR_NONE};
      @(negedge clk_i);
      n_vec++;
      if ({bus.busy_o, bus.go_o, bus.cmderr_o} !== exp) begin
        n_err++;
        $display("FAIL clear_set c%0d busy,go,cmderr got %b,%b,%0d want %b,%b,%0d",
                 c, bus.busy_o, bus.go_o, bus.cmderr_o, exp[4], exp[3], exp[2:0]);
      end
      next_cycle();
    end
  endtask

  task automatic test_timeout(input logic with_ack);
    int unsigned dg, go_end;
    logic [4:0]  exp;
    dg     = $urandom_range(0, 5);
    go_end = with_ack ? 2 + dg : 2 + TO;
    for (int unsigned c = 0; c <= TO + 5; c++) begin
      drive_idle();
      bus.cmd_we_i         = (c == 0);
      bus.cmd_wdata_i      = $urandom;
      bus.hart_going_ack_i = with_ack && (c == 2 + dg);
      bus.cmderr_we_i      = (c == TO + 4);
      bus.cmderr_wdata_i   = 3'b111;
      // GO entered at cycle 2; abort visible TO+1 cycles later
      exp = {(c >= 1 && c <= TO + 2), (c >= 2 && c <= go_end),
             (c >= TO + 3 && c <= TO + 4) ? CMDERR_OTHER : CMDERR_NONE};
      @(negedge clk_i);
      n_vec++;
      if ({bus.busy_o, bus.go_o, bus.cmderr_o} !== exp) begin
        n_err++;
        $display("FAIL timeout ack%0d c%0d busy,go,cmderr got %b,%b,%0d want %b,%b,%0d",
                 with_ack, c, bus.busy_o, bus.go_o, bus.cmderr_o, exp[4], exp[3], exp[2:0]);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, want;
    logic [4:0]  exp;
    a = $urandom | 32'h1;
    for (int unsigned c = 0; c <= 6; c++) begin
      drive_idle();
      rst_i                 = (c == 4);
      bus.cmd_we_i          = (c == 0);
      bus.cmd_wdata_i       = a;
      bus.hart_going_ack_i  = (c == 2);
      bus.dmi_busy_access_i = (c == 3);
      exp  = {(c >= 1 && c <= 4), (c == 2), (c == 4) ? CMDERR_BUSY : CMDERR_NONE};
      want = (c >= 1 && c <= 4) ? a : 32'd0;
      @(negedge clk_i);
      n_vec++;
      if ({bus.busy_o, bus.go_o, bus.cmderr_o} !== exp) begin
        n_err++;
        $display("FAIL reset_mid c%0d busy,go,cmderr got %b,%b,%0d want %b,%b,%0d",
                 c, bus.busy_o, bus.go_o, bus.cmderr_o, exp[4], exp[3], exp[2:0]);
      end
      if (c >= 1) begin
        n_vec++;
        if (bus.cmd_o !== want) begin
          n_err++;
          $display("FAIL reset_mid_cmd c%0d got %h want %h", c, bus.cmd_o, want);
        end
      end
      next_cycle();
    end
    rst_i = 1'b0;
  endtask

  task automatic test_autoexec();
    logic [31:0] a, b, want;
    logic [4:0]  exp;
    a = $urandom;
    b = a ^ 32'hFFFF_0000;
`ifdef DM_AUTOEXEC_EN
    // write, autoexec rerun, then write+autoexec together (write wins)
    for (int unsigned c = 0; c <= 12; c++) begin
      drive_idle();
      bus.cmd_we_i          = (c == 0) || (c == 8);
      bus.cmd_wdata_i       = (c == 0) ? a : b;
      bus.autoexec_trig_i   = (c == 4) || (c == 8);
      bus.hart_going_ack_i  = (c % 4) == 2;
      bus.hart_halted_ack_i = (c % 4) == 3;
      exp  = {((c % 4) != 0) && (c < 12), (c % 4) == 2, CMDERR_NONE};
      want = (c <= 8) ? a : b;
`else
    // trigger while busy and while idle must do nothing
    for (int unsigned c = 0; c <= 8; c++) begin
      drive_idle();
      bus.cmd_we_i          = (c == 0);
      bus.cmd_wdata_i       = a;
      bus.autoexec_trig_i   = (c == 1) || (c == 4) || (c == 5);
      bus.hart_going_ack_i  = (c == 2);
      bus.hart_halted_ack_i = (c == 3);
      exp  = {(c >= 1 && c <= 3), (c == 2), CMDERR_NONE};
      want = a;
`endif
      @(negedge clk_i);
      n_vec++;
      if ({bus.busy_o, bus.go_o, bus.cmderr_o} !== exp) begin
        n_err++;
        $display("FAIL autoexec c%0d busy,go,cmderr got %b,%b,%0d want %b,%b,%0d",
                 c, bus.busy_o, bus.go_o, bus.cmderr_o, exp[4], exp[3], exp[2:0]);
      end
      if (c >= 1) begin
        n_vec++;
        if (bus.cmd_o !== want) begin
          n_err++;
          $display("FAIL autoexec_cmd c%0d got %h want %h", c, bus.cmd_o, want);
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    rst_i        = 1'b1;
    bus.halted_i = 1'b1;
    drive_idle();
    test_reset();
    test_command(8);
    test_back_to_back();
    test_not_halted();
    test_unsupported();
    test_busy_err();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid();
    test_autoexec();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit reached with %0d vectors applied", n_vec);
    $fatal(1);
  end

endmodule
